cmd_relay_buffer: RTL and testbench



---
 rtl/cmd_relay_buffer.sv | 158 +++++++++++++++
 tb/tb_cmd_relay_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_relay_buffer.sv
// ----------------------------------------------------------------------------
// cmd_relay_buffer
// Buffers one command's worth of data from an upstream read handle and then
// serves it to a downstream read handle.
//
// Flow: IDLE accepts a command (region end = last word index), FILL requests
// words one at a time into a local buffer (truncating at DEPTH words), DRAIN
// announces the command with cmd_send and serves random-access reads until
// cmd_done.
//
// Optional feature: define CMD_RELAY_CHECKSUM_EN to append an XOR checksum
// word at index len+1 of the downstream region.
//
// Ports
//   clk, rst_L        clock, asynchronous active-low reset
//   cmd_ready         upstream command available (sampled in IDLE)
//   in_region_end     last word index of the upstream region
//   in_r_en           upstream read request
//   in_done, in_data  upstream read-data valid and data
//   out_region_end    last valid downstream word index
//   out_ptr, out_r_en downstream read address and request
//   out_done,out_data downstream read-data pulse and data
//   cmd_send          one-cycle pulse: buffered command ready downstream
//   cmd_done          downstream finished consuming
//   busy              FSM not idle
//   trunc_err         last accepted command exceeded DEPTH words
// ----------------------------------------------------------------------------
module cmd_relay_buffer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_L,
   input  logic              cmd_ready,
   input  logic [31:0]       in_region_end,
   output logic              in_r_en,
   input  logic              in_done,
   input  logic [DATA_W-1:0] in_data,
   output logic [31:0]       out_region_end,
   input  logic [31:0]       out_ptr,
   input  logic              out_r_en,
   output logic              out_done,
   output logic [DATA_W-1:0] out_data,
   output logic              cmd_send,
   input  logic              cmd_done,
   output logic              busy,
   output logic              trunc_err
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [31:0] MAX_IDX = 32'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     idx;
   logic [AW-1:0]     len;
   logic [DATA_W-1:0] rd_word;

`ifdef CMD_RELAY_CHECKSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   // Downstream read mux: buffer word, checksum slot, or zero past the region.
   always_comb begin
      rd_word = mem_q[out_ptr[AW-1:0]];
`ifdef CMD_RELAY_CHECKSUM_EN
      // Checksum slot may sit at index DEPTH, which aliases buffer word 0.
      if (out_ptr == (32'(len) + 32'd1)) rd_word = csum;
`endif
      if (out_ptr > out_region_end) rd_word = '0;
   end

   // Control FSM with registered outputs and buffer storage.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state          <= IDLE;
         idx            <= '0;
         len            <= '0;
         in_r_en        <= 1'b0;
         cmd_send       <= 1'b0;
         out_done       <= 1'b0;
         out_data       <= '0;
         out_region_end <= '0;
         busy           <= 1'b0;
         trunc_err      <= 1'b0;
`ifdef CMD_RELAY_CHECKSUM_EN
         csum           <= '0;
`endif
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         cmd_send <= 1'b0;
         out_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_ready) begin
                  state   <= FILL;
                  busy    <= 1'b1;
                  idx     <= '0;
                  in_r_en <= 1'b1;
                  if (in_region_end > MAX_IDX) begin
                     len       <= AW'(MAX_IDX);
                     trunc_err <= 1'b1;
                  end else begin
                     len       <= AW'(in_region_end);
                     trunc_err <= 1'b0;
                  end
`ifdef CMD_RELAY_CHECKSUM_EN
                  csum <= '0;
`endif
               end
            end

            FILL: begin
               if (in_r_en && in_done) begin
                  mem_q[idx] <= in_data;
                  in_r_en    <= 1'b0;
                  idx        <= idx + AW'(1);
`ifdef CMD_RELAY_CHECKSUM_EN
                  csum <= csum ^ in_data;
`endif
                  if (idx == len) begin
                     state    <= DRAIN;
                     cmd_send <= 1'b1;
`ifdef CMD_RELAY_CHECKSUM_EN
                     out_region_end <= 32'(len) + 32'd1;
`else
                     out_region_end <= 32'(len);
`endif
                  end
               end else if (!in_r_en) begin
                  // One idle cycle after each accepted beat, then re-request.
                  in_r_en <= 1'b1;
               end
            end

            DRAIN: begin
               if (out_r_en && !out_done) begin
                  out_done <= 1'b1;
                  out_data <= rd_word;
               end
               if (cmd_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               in_r_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_relay_buffer.sv
// ----------------------------------------------------------------------------
// tb_cmd_relay_buffer
// Directed bench for cmd_relay_buffer (DATA_W=32, DEPTH=16): reset values,
// basic transfer, truncation, stalled upstream, reset mid-FILL, zero-length
// region, out-of-range and checksum reads.
// ----------------------------------------------------------------------------
module tb_cmd_relay_buffer;

`ifdef CMD_RELAY_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_L;
   logic        cmd_ready;
   logic [31:0] in_region_end;
   logic        in_r_en;
   logic        in_done;
   logic [31:0] in_data;
   logic [31:0] out_region_end;
   logic [31:0] out_ptr;
   logic        out_r_en;
   logic        out_done;
   logic [31:0] out_data;
   logic        cmd_send;
   logic        cmd_done;
   logic        busy;
   logic        trunc_err;

   int checks   = 0;
   int errors   = 0;
   int send_cnt = 0;
   int acc_cnt  = 0;

   logic [31:0] wv [16];

   cmd_relay_buffer #(.DATA_W(32), .DEPTH(16)) dut (
      .clk            (clk),
      .rst_L          (rst_L),
      .cmd_ready      (cmd_ready),
      .in_region_end  (in_region_end),
      .in_r_en        (in_r_en),
      .in_done        (in_done),
      .in_data        (in_data),
      .out_region_end (out_region_end),
      .out_ptr        (out_ptr),
      .out_r_en       (out_r_en),
      .out_done       (out_done),
      .out_data       (out_data),
      .cmd_send       (cmd_send),
      .cmd_done       (cmd_done),
      .busy           (busy),
      .trunc_err      (trunc_err)
   );

   always #5 clk = ~clk;

   // Count cmd_send pulses and accepted upstream beats mid-cycle.
   always @(negedge clk) begin
      if (cmd_send === 1'b1) send_cnt++;
      if (in_r_en === 1'b1 && in_done === 1'b1) acc_cnt++;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_cmd(input logic [31:0] region);
      in_region_end = region;
      cmd_ready     = 1'b1;
      step;
      cmd_ready     = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_req", 32'(in_r_en), 32'd1);
   endtask

   // Upstream responder: serves n beats from wv with 'stall' wait cycles each.
   task automatic fill(input int n, input int stall, input bit last);
      for (int b = 0; b < n; b++) begin
         int t = 0;
         while (in_r_en !== 1'b1 && t < 20) begin
            step;
            t++;
         end
         if (in_r_en !== 1'b1) begin
            check("fill_timeout", 32'(in_r_en), 32'd1);
            return;
         end
         for (int s = 0; s < stall; s++) begin
            step;
            check("stall_hold", 32'(in_r_en), 32'd1);
         end
         in_done = 1'b1;
         in_data = wv[b];
         step;
         in_done = 1'b0;
         in_data = 32'hFFFF_FFFF;
         check("accept_clear", 32'(in_r_en), 32'd0);
         if (last && b == n - 1) check("cmd_send_pulse", 32'(cmd_send), 32'd1);
      end
   endtask

   task automatic rd(input logic [31:0] ptr, input logic [31:0] exp);
      out_ptr  = ptr;
      out_r_en = 1'b1;
      step;
      out_r_en = 1'b0;
      check("rd_done", 32'(out_done), 32'd1);
      check("rd_data", out_data, exp);
      step;
      check("rd_done_low", 32'(out_done), 32'd0);
      check("rd_hold", out_data, exp);
   endtask

   task automatic finish_cmd;
      cmd_done = 1'b1;
      step;
      cmd_done = 1'b0;
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_r_en"}, 32'(in_r_en), 32'd0);
      check({tag, "_cmd_send"}, 32'(cmd_send), 32'd0);
      check({tag, "_out_done"}, 32'(out_done), 32'd0);
      check({tag, "_out_data"}, out_data, 32'd0);
      check({tag, "_out_region_end"}, out_region_end, 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_trunc_err"}, 32'(trunc_err), 32'd0);
   endtask

   initial begin
      logic [31:0] cs;
      int          s0;
      int          a0;

      rst_L = 1'b0; cmd_ready = 1'b0; in_region_end = '0; in_done = 1'b0;
      in_data = '0; out_ptr = '0; out_r_en = 1'b0; cmd_done = 1'b0;
      step; step;
      check_all_zero("reset");
      rst_L = 1'b1;
      step;

      // Basic transfer, region end 3.
      wv[0] = 32'hDEAD_0000; wv[1] = 32'h1234_5678;
      wv[2] = 32'hCAFE_F00D; wv[3] = 32'h0BAD_BEEF;
      cs = wv[0] ^ wv[1] ^ wv[2] ^ wv[3];
      s0 = send_cnt;
      start_cmd(32'd3);
      check("basic_trunc", 32'(trunc_err), 32'd0);
      cmd_done = 1'b1;  // ignored outside DRAIN
      step;
      cmd_done = 1'b0;
      check("cmd_done_ignored", 32'(busy), 32'd1);
      fill(4, 0, 1'b1);
      check("basic_region_end", out_region_end, 32'(3 + CS));
      step;
      check("cmd_send_one_cycle", 32'(cmd_send), 32'd0);
      check("basic_send_cnt", 32'(send_cnt - s0), 32'd1);
      for (int p = 0; p < 4; p++) rd(32'(p), wv[p]);
      rd(32'd4, (CS == 1) ? cs : 32'd0);
      rd(32'd10, 32'd0);
      finish_cmd();
      check("hold_after_done", out_data, 32'd0);

      // Truncation: region end 20 with DEPTH 16.
      for (int i = 0; i < 16; i++) wv[i] = 32'h0000_0100 + 32'(i) * 32'h0001_0001;
      cs = '0;
      for (int i = 0; i < 16; i++) cs = cs ^ wv[i];
      a0 = acc_cnt;
      start_cmd(32'd20);
      check("trunc_flag", 32'(trunc_err), 32'd1);
      fill(16, 0, 1'b1);
      check("trunc_region_end", out_region_end, 32'(15 + CS));
      for (int i = 0; i < 3; i++) begin
         step;
         check("trunc_no_extra_req", 32'(in_r_en), 32'd0);
      end
      check("trunc_beats", 32'(acc_cnt - a0), 32'd16);
      rd(32'd15, wv[15]);
      rd(32'd0, wv[0]);
      rd(32'd16, (CS == 1) ? cs : 32'd0);
      finish_cmd();
      check("trunc_held_idle", 32'(trunc_err), 32'd1);

      // Stalled upstream: 5 wait cycles per beat, region end 1.
      wv[0] = 32'hA5A5_0001; wv[1] = 32'h5A5A_0002;
      start_cmd(32'd1);
      check("trunc_cleared", 32'(trunc_err), 32'd0);
      fill(2, 5, 1'b1);
      check("stall_region_end", out_region_end, 32'(1 + CS));
      rd(32'd1, wv[1]);
      rd(32'd0, wv[0]);
      finish_cmd();

      // Reset mid-FILL after 2 beats, then a 1-word command.
      wv[0] = 32'h1111_1111; wv[1] = 32'h2222_2222;
      s0 = send_cnt;
      start_cmd(32'd5);
      fill(2, 0, 1'b0);
      step;
      check("midfill_rereq", 32'(in_r_en), 32'd1);
      #2 rst_L = 1'b0;
      #1;
      check_all_zero("midfill_reset");
      step;
      check("midfill_no_send", 32'(send_cnt - s0), 32'd0);
      rst_L = 1'b1;
      step;

      wv[0] = 32'h5A5A_A5A5;
      a0 = acc_cnt;
      start_cmd(32'd0);
      fill(1, 0, 1'b1);
      check("zero_len_beats", 32'(acc_cnt - a0), 32'd1);
      check("zero_len_region_end", out_region_end, 32'(CS));
      step;
      check("zero_len_no_req", 32'(in_r_en), 32'd0);
      rd(32'd0, wv[0]);
      rd(32'd1, (CS == 1) ? wv[0] : 32'd0);
      // Read in flight on the cmd_done edge still completes.
      out_ptr  = 32'd0;
      out_r_en = 1'b1;
      cmd_done = 1'b1;
      step;
      out_r_en = 1'b0;
      cmd_done = 1'b0;
      check("done_edge_out_done", 32'(out_done), 32'd1);
      check("done_edge_data", out_data, wv[0]);
      check("done_edge_busy", 32'(busy), 32'd0);

      // Checksum words 1,2,4,8 and out-of-range read.
      wv[0] = 32'd1; wv[1] = 32'd2; wv[2] = 32'd4; wv[3] = 32'd8;
      start_cmd(32'd3);
      fill(4, 0, 1'b1);
      check("csum_region_end", out_region_end, 32'(3 + CS));
      rd(32'd4, (CS == 1) ? 32'h0000_000F : 32'd0);
      rd(32'd10, 32'd0);
      rd(32'd2, 32'd4);
      finish_cmd();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
